slice_column_sequencer: RTL
===========================

# slice_column_sequencer

Frame-level driver for the slice-height calculator and the VGA pixel plotter. On a frame start it walks `column_count` across all screen columns. For each column it issues one `begin_calc` request to the height calculator, waits for `end_calc`, and captures `slice_size`. It then plots that column as ceiling, wall and floor pixels into the VGA adapter, one pixel per cycle.

## Interface
Parameters:
- `SCREEN_W`, 160: columns per frame (0..SCREEN_W-1).
- `SCREEN_H`, 120: rows per column (0..SCREEN_H-1).
- `WALL_COLOUR`, 3'b111: colour of wall pixels.
- `CEIL_COLOUR`, 3'b001: colour above the wall.
- `FLOOR_COLOUR`, 3'b010: colour below the wall.
- `TIMEOUT`, 255: maximum number of WAIT cycles per column.

Ports:
- `clock`  in  1  system clock. One clock domain; every flop is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_frame`  in  1  begins a frame when sampled high in IDLE.
- `end_calc`  in  1  calculator done, level or pulse.
- `slice_size`  in  7  calculated height, unsigned; valid while `end_calc` is high.
- `column_count`  out  8  current column, driven to the calculator.
- `begin_calc`  out  1  single-cycle request to the calculator.
- `plot`  out  1  pixel write enable to the VGA adapter.
- `x`  out  8  pixel column.
- `y`  out  7  pixel row.
- `colour`  out  3  pixel colour.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.
- `timeout_flag`  out  1  sticky; set by any column timeout and cleared on accepted `start_frame`.

## Operation
States: IDLE, REQ, WAIT, DRAW, NEXT.
- **IDLE:** `start_frame` high moves to REQ, sets `column_count`=0 and clears `timeout_flag`. `start_frame` in any other state is ignored.
- **REQ:** `begin_calc`=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
- **WAIT:** the wait counter increments every cycle.
  - `end_calc` is ignored in the first WAIT cycle, to discard a stale level from the previous column.
  - From the second cycle on, `end_calc` high latches h = min(`slice_size`, SCREEN_H), sets `y`=0 and goes to DRAW.
  - If the counter reaches TIMEOUT first: h=0, set `timeout_flag`, go to DRAW.
- **Wall bounds:** computed in 8-bit unsigned arithmetic, with no sign issues after clipping.
  - top = (SCREEN_H − h) >> 1
  - bot = top + h
- **DRAW:** `plot`=1 with `x`=`column_count` and the current `y`.
  - `colour` = CEIL_COLOUR if y < top; WALL_COLOUR if top ≤ y < bot; FLOOR_COLOUR if y ≥ bot.
  - `y` increments each cycle. After `y`=SCREEN_H−1 has been driven, go to NEXT.
- **NEXT:** `plot`=0.
  - If `column_count`=SCREEN_W−1: pulse `frame_done` and go to IDLE, with `column_count` returning to 0.
  - Otherwise increment `column_count` and go to REQ.
- **`end_calc` outside WAIT:** ignored in IDLE, REQ, DRAW and NEXT.

## Timing
- **Registered outputs:** all outputs are registered and change only on rising `clock`.
- **Reset values:** state=IDLE. `column_count`, `begin_calc`, `plot`, `x`, `y`, `colour`, `busy`, `frame_done` and `timeout_flag` are all 0.
- **Reset mid-frame:** asynchronous reset forces the reset values immediately. No partial column completes, and no `frame_done` is issued.
- **Start to first request:** `start_frame` sampled at edge N gives `begin_calc` high during cycle N+1.
- **Column stability:** `column_count` is stable from REQ through NEXT of that column.
- **Per-column latency:** 1 (REQ) + W (WAIT cycles, 2 ≤ W ≤ TIMEOUT) + SCREEN_H (DRAW) + 1 (NEXT).
- **Slice capture:** `slice_size` is captured on the same edge that leaves WAIT.
- **Pixel stream:** `plot` is high for exactly SCREEN_H consecutive cycles per column, with `y` = 0,1,…,SCREEN_H−1 and no gaps.
- **Frame end:** `frame_done` is high for one cycle, the cycle after the last NEXT edge, concurrent with IDLE.
- **Back-to-back frames:** a `start_frame` held high restarts on the following cycle.
- **Boundary cases:**
  - `slice_size`=0: top=bot=60; rows 0..59 ceiling, rows 60..119 floor.
  - `slice_size` ≥ 120 (including 127): all wall.
  - Odd h: the extra row goes to the floor side.

## Test plan
- **Normal column:** reset, `start_frame` pulse, calculator model returns `end_calc` with `slice_size`=40 after 5 WAIT cycles → `begin_calc` is a single pulse with `column_count`=0; 120 plots at `x`=0; rows 0–39 colour 001, rows 40–79 colour 111, rows 80–119 colour 010.
- **Clip and zero:** `slice_size`=127 → all 120 pixels 111. `slice_size`=0 → rows 0–59 001, rows 60–119 010. `slice_size`=41 → wall rows 39–79.
- **Stale end_calc:** `end_calc` held high continuously → each column still spends exactly 2 WAIT cycles; 160 `begin_calc` pulses; `frame_done` once; `column_count` returns to 0.
- **Timeout:** `end_calc` never asserted on column 7 → after 255 WAIT cycles, column 7 drawn as h=0; `timeout_flag`=1 until the next accepted `start_frame`; frame completes.
- **Reset and ignored start:** assert `reset` during DRAW of column 3 at `y`=50 → all outputs 0 immediately; IDLE after release; no `frame_done`. `start_frame` pulsed mid-frame → ignored; frame length unchanged.
- **Whole frame:** full 160-column frame with `slice_size` = column mod 128 → scoreboard of 19200 pixels matches the top/bot rule; `frame_done` exactly one cycle.

Source files
------------

// File: rtl/slice_column_sequencer.sv
// Frame sequencer: for each screen column, requests a slice height from the
// calculator, then streams that column as ceiling/wall/floor pixels to the VGA plotter.
module slice_column_sequencer #(
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] WALL_COLOUR  = 3'b111,
    parameter logic [2:0] CEIL_COLOUR  = 3'b001,
    parameter logic [2:0] FLOOR_COLOUR = 3'b010,
    parameter int         TIMEOUT      = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_frame,
    input  logic       end_calc,
    input  logic [6:0] slice_size,
    output logic [7:0] column_count,
    output logic       begin_calc,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_flag,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DRAW = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    H_MAX    = 8'(SCREEN_H);
    localparam logic [6:0]    Y_LAST   = 7'(SCREEN_H - 1);
    localparam logic [7:0]    COL_LAST = 8'(SCREEN_W - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    logic [CW-1:0] r_wait_cnt;
    logic [7:0]    r_top;
    logic [7:0]    r_bot;

    logic [7:0] w_slice_ext;
    logic [7:0] w_slice_h;
    logic       w_hit;
    logic       w_timeout;
    logic [7:0] w_new_h;
    logic [7:0] w_new_top;
    logic [7:0] w_new_bot;
    logic [6:0] w_y_next;

    function automatic logic [2:0] pixel_colour(input logic [7:0] row,
                                                input logic [7:0] top,
                                                input logic [7:0] bot);
        if (row < top)
            return CEIL_COLOUR;
        else if (row < bot)
            return WALL_COLOUR;
        else
            return FLOOR_COLOUR;
    endfunction

    // The first WAIT cycle (counter still 0) masks a stale end_calc level.
    assign w_slice_ext = {1'b0, slice_size};
    assign w_slice_h   = (w_slice_ext > H_MAX) ? H_MAX : w_slice_ext;
    assign w_hit       = (r_state == S_WAIT) && (r_wait_cnt != '0) && end_calc;
    assign w_timeout   = (r_state == S_WAIT) && !w_hit && (r_wait_cnt == CNT_LAST);
    assign w_new_h     = w_hit ? w_slice_h : 8'd0;
    assign w_new_top   = (H_MAX - w_new_h) >> 1;
    assign w_new_bot   = w_new_top + w_new_h;
    assign w_y_next    = y + 7'd1;
    assign dbg_state   = r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_top        <= 8'd0;
            r_bot        <= 8'd0;
            column_count <= 8'd0;
            begin_calc   <= 1'b0;
            plot         <= 1'b0;
            x            <= 8'd0;
            y            <= 7'd0;
            colour       <= 3'd0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            begin_calc <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_frame) begin
                        r_state      <= S_REQ;
                        column_count <= 8'd0;
                        timeout_flag <= 1'b0;
                        begin_calc   <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + CW'(1);
                    if (w_hit || w_timeout) begin
                        r_top   <= w_new_top;
                        r_bot   <= w_new_bot;
                        plot    <= 1'b1;
                        x       <= column_count;
                        y       <= 7'd0;
                        colour  <= pixel_colour(8'd0, w_new_top, w_new_bot);
                        r_state <= S_DRAW;
                        if (w_timeout)
                            timeout_flag <= 1'b1;
                    end
                end
                S_DRAW: begin
                    if (y == Y_LAST) begin
                        plot    <= 1'b0;
                        r_state <= S_NEXT;
                    end else begin
                        y      <= w_y_next;
                        colour <= pixel_colour({1'b0, w_y_next}, r_top, r_bot);
                    end
                end
                S_NEXT: begin
                    if (column_count == COL_LAST) begin
                        frame_done   <= 1'b1;
                        busy         <= 1'b0;
                        column_count <= 8'd0;
                        r_state      <= S_IDLE;
                    end else begin
                        column_count <= column_count + 8'd1;
                        begin_calc   <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
